video_timing_gen: RTL and testbench
===================================

Name: video_timing_gen

Overview:
- Parametrised raster timing generator for the pixel domain. Successor to the fixed 640x480 counter and sync logic in the HDMI path.
- Generates X/Y scan positions, data-enable, hSync and vSync with programmable timings and sync polarity.
- Has a configurable pipeline delay so that DE and syncs line up with a pixel source of known latency.
- Adds a clock-enable, line/frame strobes and a frame counter. Feeds the TMDS encoders and the pixel/sprite fetch logic.

Parameters:
- CW, 12, width of the X/Y counters; must hold H_TOTAL-1 and V_TOTAL-1.
- H_ACTIVE, 640, active pixels per line.
- H_FP, 16, horizontal front porch in pixels.
- H_SYNC, 96, hSync width in pixels.
- H_BP, 48, horizontal back porch in pixels.
- V_ACTIVE, 480, active lines per frame.
- V_FP, 10, vertical front porch in lines.
- V_SYNC, 2, vSync width in lines.
- V_BP, 33, vertical back porch in lines.
- HS_POL, 0, hSync active level (0 = active-low).
- VS_POL, 0, vSync active level.
- PIPE_DLY, 1, extra cycles of delay on drawArea/hSync/vSync; range 0..15.

Ports:
- pixelClk  in  1  pixel clock.
- reset  in  1  synchronous, active-low.
- ce  in  1  clock enable; when low, all state holds.
- screenX  out  CW  current horizontal position, undelayed.
- screenY  out  CW  current vertical position, undelayed.
- drawArea  out  1  data enable, delayed.
- hSync  out  1  horizontal sync, delayed, polarity HS_POL.
- vSync  out  1  vertical sync, delayed, polarity VS_POL.
- newLine  out  1  one-cycle strobe: last active pixel of an active line.
- newFrame  out  1  one-cycle strobe: last active pixel of the frame.
- frameCount  out  8  completed-frame count, wraps 255->0.

Behaviour:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP. V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP.
- Counters, on a cycle with ce=1:
  - X increments; X wraps H_TOTAL-1 -> 0.
  - Y increments only on the X-wrap cycle; Y wraps V_TOTAL-1 -> 0.
  - screenX/screenY are the counter registers directly, with no extra latency.
- Decode from the counters at cycle t; the result registers at t+1 and passes through a PIPE_DLY-stage shift register. Total latency from counter value to pin is 1+PIPE_DLY ce-cycles.
  - de: X<H_ACTIVE && Y<V_ACTIVE.
  - hs active: H_ACTIVE+H_FP <= X < H_ACTIVE+H_FP+H_SYNC.
  - vs active: V_ACTIVE+V_FP <= Y < V_ACTIVE+V_FP+V_SYNC. vSync changes aligned to X=0 of the line.
  - Output level = POL when active, ~POL otherwise.
  - PIPE_DLY=0 gives exactly 1 cycle of latency.
- Strobes and frame counter (registered, 1-cycle latency, not affected by PIPE_DLY):
  - newLine = (X==H_ACTIVE-1 && Y<V_ACTIVE).
  - newFrame = (X==H_ACTIVE-1 && Y==V_ACTIVE-1).
  - frameCount increments on the cycle the counters wrap from (H_TOTAL-1, V_TOTAL-1) to (0,0).
- ce=0:
  - Counters, decode registers, delay line, frameCount and all outputs hold.
  - Strobes are forced to 0 during ce=0, so a strobe is never repeated while stalled.
  - Strobes fire only on a ce=1 cycle.
- Reset (reset=0 at a pixelClk edge, regardless of ce):
  - X=0, Y=0, frameCount=0.
  - drawArea=0, hSync=~HS_POL, vSync=~VS_POL, newLine=0, newFrame=0.
  - Every delay-line stage is cleared to the same inactive values, so no stale sync or DE leaks out after reset.
  - Reset mid-frame restarts the frame at (0,0) on the next enabled cycle.
- Elaboration checks: invalid parameters fail elaboration (generate-time error), not silently.
  - Any timing parameter of 0, except porches, which may be 0.
  - Counter overflow against CW.
  - PIPE_DLY greater than 15.

Test Plan:
- Defaults, ce=1, release reset -> screenX runs 0..799 and wraps. screenY steps 0->1 on the X=799->0 edge. Y wraps 524->0 after 420000 cycles; frameCount=1 at that point.
- Defaults -> hSync first goes low 2 cycles after screenX==656, stays low exactly 96 cycles. vSync low for exactly 1600 cycles starting 2 cycles after (X=0, Y=490). drawArea high for 640 cycles per line on lines 0..479 only.
- PIPE_DLY=0 and PIPE_DLY=5 -> drawArea rise lags screenX==0 by 1 and 6 cycles respectively. newLine always lags screenX==639 by 1 cycle. newFrame fires once per frame, 1 cycle after (639, 479).
- HS_POL=1, VS_POL=1 -> both syncs idle low, pulse high. Widths and positions as in the second scenario. Reset levels are 0.
- Toggle ce low for 7 cycles at screenX==639 -> all outputs frozen. newLine pulses exactly once. Count resumes at 640 and the line still totals 800 enabled cycles.
- Assert reset for 1 cycle at (X=700, Y=300) -> next cycle X=0, Y=0, drawArea=0, syncs inactive through all PIPE_DLY stages. frameCount=0. First hSync appears 656+1+PIPE_DLY cycles after release.

Source files
------------

// File: rtl/video_timing_gen.sv
// Programmable raster timing generator: X/Y scan counters, delayed DE/sync decode,
// line/frame strobes and a wrapping frame counter, all gated by a pixel clock enable.
module video_timing_gen #(
    parameter int CW       = 12,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int HS_POL   = 0,
    parameter int VS_POL   = 0,
    parameter int PIPE_DLY = 1
) (
    input  logic          pixelClk,
    input  logic          reset,
    input  logic          ce,
    output logic [CW-1:0] screenX,
    output logic [CW-1:0] screenY,
    output logic          drawArea,
    output logic          hSync,
    output logic          vSync,
    output logic          newLine,
    output logic          newFrame,
    output logic [7:0]    frameCount
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    if (H_ACTIVE < 1 || H_SYNC < 1 || V_ACTIVE < 1 || V_SYNC < 1) begin : gBadTiming
        $error("video_timing_gen: active and sync widths must be non-zero");
    end
    if (H_FP < 0 || H_BP < 0 || V_FP < 0 || V_BP < 0) begin : gBadPorch
        $error("video_timing_gen: porches must not be negative");
    end
    if (CW < 1 || CW > 30) begin : gBadCw
        $error("video_timing_gen: CW out of range");
    end else if (H_TOTAL > (1 << CW) || V_TOTAL > (1 << CW)) begin : gOverflow
        $error("video_timing_gen: CW too narrow for H_TOTAL-1 / V_TOTAL-1");
    end
    if (PIPE_DLY < 0 || PIPE_DLY > 15) begin : gBadDly
        $error("video_timing_gen: PIPE_DLY must be 0..15");
    end

    // Decode thresholds are one bit wider than the counters so an end bound equal
    // to H_TOTAL or V_TOTAL (zero back porch) is not truncated to zero.
    localparam logic [CW:0] H_ACT_W   = (CW+1)'(H_ACTIVE);
    localparam logic [CW:0] HS_BEG_W  = (CW+1)'(H_ACTIVE + H_FP);
    localparam logic [CW:0] HS_END_W  = (CW+1)'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW:0] V_ACT_W   = (CW+1)'(V_ACTIVE);
    localparam logic [CW:0] VS_BEG_W  = (CW+1)'(V_ACTIVE + V_FP);
    localparam logic [CW:0] VS_END_W  = (CW+1)'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CW-1:0] X_LAST  = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] Y_LAST  = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] X_ACT_LAST = CW'(H_ACTIVE - 1);
    localparam logic [CW-1:0] Y_ACT_LAST = CW'(V_ACTIVE - 1);
    localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};
    localparam logic HS_ON = (HS_POL != 0) ? 1'b1 : 1'b0;
    localparam logic VS_ON = (VS_POL != 0) ? 1'b1 : 1'b0;

    logic [CW-1:0] xR;
    logic [CW-1:0] yR;
    logic [7:0]    frameR;
    logic          newLineR;
    logic          newFrameR;
    logic          deS;
    logic          hsS;
    logic          vsS;
    logic [CW:0]   xWideS;
    logic [CW:0]   yWideS;
    logic          deLineR [0:PIPE_DLY];
    logic          hsLineR [0:PIPE_DLY];
    logic          vsLineR [0:PIPE_DLY];

    // Combinational decode of the current counter position into DE and sync levels.
    always_comb begin
        xWideS = {1'b0, xR};
        yWideS = {1'b0, yR};
        deS    = (xWideS < H_ACT_W) && (yWideS < V_ACT_W);
        if (xWideS >= HS_BEG_W && xWideS < HS_END_W) begin
            hsS = HS_ON;
        end else begin
            hsS = ~HS_ON;
        end
        if (yWideS >= VS_BEG_W && yWideS < VS_END_W) begin
            vsS = VS_ON;
        end else begin
            vsS = ~VS_ON;
        end
    end

    // Scan counters, frame counter and the undelayed line/frame strobes.
    always_ff @(posedge pixelClk) begin
        if (!reset) begin
            xR        <= {CW{1'b0}};
            yR        <= {CW{1'b0}};
            frameR    <= 8'd0;
            newLineR  <= 1'b0;
            newFrameR <= 1'b0;
        end else if (ce) begin
            newLineR  <= (xR == X_ACT_LAST) && (yWideS < V_ACT_W);
            newFrameR <= (xR == X_ACT_LAST) && (yR == Y_ACT_LAST);
            if (xR == X_LAST) begin
                xR <= {CW{1'b0}};
                if (yR == Y_LAST) begin
                    yR     <= {CW{1'b0}};
                    frameR <= frameR + 8'd1;
                end else begin
                    yR <= yR + CNT_ONE;
                end
            end else begin
                xR <= xR + CNT_ONE;
            end
        end else begin
            // Strobes drop while stalled so a pulse is never stretched or repeated.
            newLineR  <= 1'b0;
            newFrameR <= 1'b0;
        end
    end

    // Decode register (stage 0) followed by PIPE_DLY alignment stages.
    always_ff @(posedge pixelClk) begin
        if (!reset) begin
            for (int i = 0; i <= PIPE_DLY; i++) begin
                deLineR[i] <= 1'b0;
                hsLineR[i] <= ~HS_ON;
                vsLineR[i] <= ~VS_ON;
            end
        end else if (ce) begin
            deLineR[0] <= deS;
            hsLineR[0] <= hsS;
            vsLineR[0] <= vsS;
            for (int i = 1; i <= PIPE_DLY; i++) begin
                deLineR[i] <= deLineR[i-1];
                hsLineR[i] <= hsLineR[i-1];
                vsLineR[i] <= vsLineR[i-1];
            end
        end else begin
            for (int i = 0; i <= PIPE_DLY; i++) begin
                deLineR[i] <= deLineR[i];
                hsLineR[i] <= hsLineR[i];
                vsLineR[i] <= vsLineR[i];
            end
        end
    end

    assign screenX    = xR;
    assign screenY    = yR;
    assign drawArea   = deLineR[PIPE_DLY];
    assign hSync      = hsLineR[PIPE_DLY];
    assign vSync      = vsLineR[PIPE_DLY];
    assign newLine    = newLineR;
    assign newFrame   = newFrameR;
    assign frameCount = frameR;

endmodule

// File: tb/tb_video_timing_gen.sv
// Scoreboard bench for video_timing_gen on a small raster: a position/delay-queue
// model predicts every post-edge output; a monitor compares each clock.
module tb_video_timing_gen;

    localparam int CW  = 5;
    localparam int HA  = 8;
    localparam int HFP = 2;
    localparam int HSW = 3;
    localparam int HBP = 0;
    localparam int VA  = 4;
    localparam int VFP = 0;
    localparam int VSW = 2;
    localparam int VBP = 1;
    localparam int HSP = 1;
    localparam int VSP = 0;
    localparam int PD  = 2;
    localparam int HT  = HA + HFP + HSW + HBP;
    localparam int VT  = VA + VFP + VSW + VBP;

    typedef struct packed {
        logic [CW-1:0] x;
        logic [CW-1:0] y;
        logic          de;
        logic          hs;
        logic          vs;
        logic          nl;
        logic          nf;
        logic [7:0]    fc;
    } exp_t;

    logic          pixelClk = 1'b0;
    logic          reset = 1'b0;
    logic          ce = 1'b0;
    logic [CW-1:0] screenX;
    logic [CW-1:0] screenY;
    logic          drawArea;
    logic          hSync;
    logic          vSync;
    logic          newLine;
    logic          newFrame;
    logic [7:0]    frameCount;

    video_timing_gen #(
        .CW(CW), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
        .HS_POL(HSP), .VS_POL(VSP), .PIPE_DLY(PD)
    ) dut (
        .pixelClk(pixelClk), .reset(reset), .ce(ce),
        .screenX(screenX), .screenY(screenY), .drawArea(drawArea),
        .hSync(hSync), .vSync(vSync), .newLine(newLine), .newFrame(newFrame),
        .frameCount(frameCount)
    );

    always #5 pixelClk = ~pixelClk;

    int total = 0;
    int bad = 0;
    exp_t expQ[$];

    // Reference model: raster position, frame count and a queue of decoded
    // {de,hs,vs} triples whose oldest entry is what the pins show.
    int mx = 0;
    int my = 0;
    int mfc = 0;
    logic mnl = 1'b0;
    logic mnf = 1'b0;
    logic [2:0] hist[$];

    function automatic logic [2:0] inactive();
        return {1'b0, (HSP != 0) ? 1'b0 : 1'b1, (VSP != 0) ? 1'b0 : 1'b1};
    endfunction

    function automatic logic [2:0] decodeAt(input int x, input int y);
        logic d, h, v;
        d = (x < HA) && (y < VA);
        h = (x >= HA + HFP && x < HA + HFP + HSW) ? (HSP != 0) : (HSP == 0);
        v = (y >= VA + VFP && y < VA + VFP + VSW) ? (VSP != 0) : (VSP == 0);
        return {d, h, v};
    endfunction

    task automatic stepModel(input logic r, input logic c, output exp_t e);
        logic [2:0] cur;
        if (!r) begin
            mx = 0; my = 0; mfc = 0; mnl = 1'b0; mnf = 1'b0;
            hist = {};
            for (int i = 0; i <= PD; i++) hist.push_back(inactive());
        end else if (c) begin
            hist.push_back(decodeAt(mx, my));
            void'(hist.pop_front());
            mnl = (mx == HA - 1) && (my < VA);
            mnf = (mx == HA - 1) && (my == VA - 1);
            if (mx == HT - 1 && my == VT - 1) mfc = (mfc + 1) % 256;
            if (mx == HT - 1) begin
                mx = 0;
                my = (my + 1) % VT;
            end else begin
                mx = mx + 1;
            end
        end else begin
            mnl = 1'b0; mnf = 1'b0;
        end
        cur = hist[0];
        e.x  = CW'(mx);
        e.y  = CW'(my);
        e.de = cur[2];
        e.hs = cur[1];
        e.vs = cur[0];
        e.nl = mnl;
        e.nf = mnf;
        e.fc = 8'(mfc);
    endtask

    task automatic drive(input logic r, input logic c);
        exp_t e;
        @(negedge pixelClk);
        reset = r;
        ce = c;
        stepModel(r, c, e);
        expQ.push_back(e);
    endtask

    // Monitor: one expected entry per clock edge, compared just after the edge.
    initial begin
        exp_t e, got;
        forever begin
            @(posedge pixelClk);
            #1;
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                got = {screenX, screenY, drawArea, hSync, vSync, newLine, newFrame, frameCount};
                total++;
                if (got !== e) begin
                    bad++;
                    $display("FAIL cycle t=%0t got x=%0d y=%0d de=%b hs=%b vs=%b nl=%b nf=%b fc=%0d want x=%0d y=%0d de=%b hs=%b vs=%b nl=%b nf=%b fc=%0d",
                             $time, got.x, got.y, got.de, got.hs, got.vs, got.nl, got.nf, got.fc,
                             e.x, e.y, e.de, e.hs, e.vs, e.nl, e.nf, e.fc);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        drive(1'b0, 1'b1);
        drive(1'b0, 1'b0);
        drive(1'b0, 1'b1);
        for (int i = 0; i < 300; i++) drive(1'b1, 1'b1);

        // Stall on the last active pixel of an active line.
        guard = 0;
        while (!(mx == HA - 1 && my < VA) && guard < 500) begin
            drive(1'b1, 1'b1);
            guard++;
        end
        total++;
        if (guard >= 500) begin
            bad++;
            $display("FAIL stall_search got guard=%0d want <500", guard);
        end
        for (int i = 0; i < 7; i++) drive(1'b1, 1'b0);
        for (int i = 0; i < 120; i++) drive(1'b1, 1'b1);

        // Reset in the middle of the last active line.
        guard = 0;
        while (!(mx == HA + 2 && my == VA - 1) && guard < 500) begin
            drive(1'b1, 1'b1);
            guard++;
        end
        total++;
        if (guard >= 500) begin
            bad++;
            $display("FAIL reset_search got guard=%0d want <500", guard);
        end
        drive(1'b0, 1'b1);
        for (int i = 0; i < 200; i++) drive(1'b1, 1'b1);

        for (int i = 0; i < 3000; i++)
            drive(($urandom_range(0, 199) != 0), ($urandom_range(0, 3) != 0));

        // Long enabled run so frameCount wraps 255 -> 0.
        drive(1'b0, 1'b1);
        for (int i = 0; i < 257 * HT * VT + 40; i++) drive(1'b1, 1'b1);

        @(posedge pixelClk);
        #3;
        total++;
        if (expQ.size() != 0) begin
            bad++;
            $display("FAIL drain got pending=%0d want 0", expQ.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
